fetch_unit: RTL and testbench

Instruction-fetch stage. Holds the program counter, issues one word-aligned request at a time to instruction memory, and buffers each returned instruction with its PC for decode behind a valid/ready handshake. Consumes `br_en`/`br_target` from `branch_ctrl` and execute, redirecting the PC and squashing stale fetches on a taken branch or jump.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_unit_if_buffer.sv | 35 +++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and fetch-stage types used by fetch, branch_ctrl and decode.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // Instruction addresses are always word aligned; low bits are discarded.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_unit_if_buffer.sv
// Single-entry decode buffer: holds one {pc, instr} pair behind a valid/ready handshake.
module if_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  // NOTE: the payload is reset along with valid so if_pc/if_instr never show X downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else begin
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (drain) valid <= 1'b0;

      if (load && !flush) begin
        pc    <= load_pc;
        instr <= load_instr;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, and decode buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_en,
  input  logic [XLEN-1:0] br_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;

  logic drain;
  logic buf_free;
  logic accept;
  logic load;

  assign drain    = if_valid & if_ready;
  assign buf_free = !if_valid | drain;

  // A request leaves only when its response is guaranteed a free buffer slot.
  assign imem_req_valid = (state == S_REQ) & buf_free & !rst;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign load           = (state == S_WAIT) & imem_rsp_valid & !br_en;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inflight_pc <= '0;
    end else if (br_en) begin
      pc <= word_align(br_target);
      case (state)
        S_REQ:   state <= accept ? S_DROP : S_REQ;
        S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state <= imem_rsp_valid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (accept) begin
            inflight_pc <= pc;
            pc          <= pc + PC_STEP;
            state       <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rsp_valid) state <= S_REQ;
        S_DROP:  if (imem_rsp_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  if_buffer u_if_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .drain      (drain),
    .flush      (br_en),
    .load_pc    (inflight_pc),
    .load_instr (imem_rsp_data),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, PC wrap check, and random run vs a transaction model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_en;
  logic [31:0] br_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;
  logic        w_if_ready;
  logic        w_req_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .br_en(br_en), .br_target(br_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_ready(if_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .br_en(1'b0), .br_target(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(w_req_ready), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .if_valid(w_if_valid), .if_pc(w_if_pc),
    .if_instr(w_if_instr), .if_ready(w_if_ready)
  );

  typedef struct {
    logic        r;
    logic        br;
    logic [31:0] tgt;
    logic        rr;
    logic        rv;
    logic        ir;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_1357;
  endfunction

  function automatic vec_t mk(input logic r, input logic br, input logic [31:0] tgt,
                              input logic rr, input logic rv, input logic ir,
                              input logic e_rv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_ipc);
    vec_t v;
    v.r = r; v.br = br; v.tgt = tgt; v.rr = rr; v.rv = rv; v.ir = ir;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] acc_addr;

  // Transaction-level reference: next pc, one optional outstanding fetch, one optional buffered word.
  logic [31:0] m_pc, m_oaddr, m_bpc, m_binstr;
  logic        m_out, m_stale, m_bv;

  initial begin
    rst = 1'b1; br_en = 1'b0; br_target = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0; w_if_ready = 1'b0;
    acc_addr = '0;
    tick();
    check("rst_req_valid", 0, {31'b0, imem_req_valid}, 32'd0);
    tick();

    // PC wrap from the top of the address space.
    rst = 1'b0; w_req_ready = 1'b1; w_if_ready = 1'b1;
    #1;
    check("wrap_req_valid0", 0, {31'b0, w_req_valid}, 32'd1);
    check("wrap_addr0", 0, w_req_addr, 32'hFFFF_FFFC);
    tick();
    w_rsp_valid = 1'b1; w_rsp_data = 32'h0000_1234;
    #1;
    check("wrap_req_valid1", 1, {31'b0, w_req_valid}, 32'd0);
    check("wrap_addr1", 1, w_req_addr, 32'h0000_0000);
    tick();
    w_rsp_valid = 1'b0;
    #1;
    check("wrap_if_valid", 2, {31'b0, w_if_valid}, 32'd1);
    check("wrap_if_pc", 2, w_if_pc, 32'hFFFF_FFFC);
    check("wrap_if_instr", 2, w_if_instr, 32'h0000_1234);
    check("wrap_req_valid2", 2, {31'b0, w_req_valid}, 32'd1);
    check("wrap_addr2", 2, w_req_addr, 32'h0000_0000);
    w_req_ready = 1'b0;

    //           rst  br  tgt           rr  rv  ir   e_rv e_addr         e_iv e_ipc
    tbl[0]  = mk(1'b1, 0, 32'h0,        1,  0,  1,   0, 32'h0000_0000,   0, 32'h0);
    tbl[1]  = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_0000,   0, 32'h0);
    tbl[2]  = mk(1'b0, 0, 32'h0,        1,  1,  1,   0, 32'h0000_0004,   0, 32'h0);
    tbl[3]  = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_0004,   1, 32'h0);
    tbl[4]  = mk(1'b0, 0, 32'h0,        1,  1,  1,   0, 32'h0000_0008,   0, 32'h0);
    tbl[5]  = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_0008,   1, 32'h4);
    tbl[6]  = mk(1'b0, 0, 32'h0,        1,  1,  1,   0, 32'h0000_000C,   0, 32'h0);
    tbl[7]  = mk(1'b0, 0, 32'h0,        1,  0,  0,   0, 32'h0000_000C,   1, 32'h8);
    tbl[8]  = mk(1'b0, 0, 32'h0,        1,  0,  0,   0, 32'h0000_000C,   1, 32'h8);
    tbl[9]  = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_000C,   1, 32'h8);
    tbl[10] = mk(1'b0, 0, 32'h0,        1,  1,  1,   0, 32'h0000_0010,   0, 32'h0);
    tbl[11] = mk(1'b0, 0, 32'h0,        0,  0,  1,   1, 32'h0000_0010,   1, 32'hC);
    tbl[12] = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_0010,   0, 32'h0);
    tbl[13] = mk(1'b0, 1, 32'h0000_0102, 1, 0,  1,   0, 32'h0000_0014,   0, 32'h0);
    tbl[14] = mk(1'b0, 0, 32'h0,        1,  1,  1,   0, 32'h0000_0100,   0, 32'h0);
    tbl[15] = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_0100,   0, 32'h0);
    tbl[16] = mk(1'b0, 1, 32'h0000_0040, 1, 1,  1,   0, 32'h0000_0104,   0, 32'h0);
    tbl[17] = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_0040,   0, 32'h0);
    tbl[18] = mk(1'b0, 0, 32'h0,        1,  1,  1,   0, 32'h0000_0044,   0, 32'h0);
    tbl[19] = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_0044,   1, 32'h40);
    tbl[20] = mk(1'b1, 0, 32'h0,        1,  0,  1,   0, 32'h0000_0048,   0, 32'h0);
    tbl[21] = mk(1'b0, 0, 32'h0,        1,  0,  1,   1, 32'h0000_0000,   0, 32'h0);

    for (int i = 0; i < 22; i++) begin
      rst            = tbl[i].r;
      br_en          = tbl[i].br;
      br_target      = tbl[i].tgt;
      imem_req_ready = tbl[i].rr;
      imem_rsp_valid = tbl[i].rv;
      imem_rsp_data  = mem_word(acc_addr);
      if_ready       = tbl[i].ir;
      #1;
      check("tbl_req_valid", i, {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
      check("tbl_req_addr", i, imem_req_addr, tbl[i].e_addr);
      check("tbl_if_valid", i, {31'b0, if_valid}, {31'b0, tbl[i].e_iv});
      if (tbl[i].e_iv) begin
        check("tbl_if_pc", i, if_pc, tbl[i].e_ipc);
        check("tbl_if_instr", i, if_instr, mem_word(tbl[i].e_ipc));
      end
      if (imem_req_valid && tbl[i].rr) acc_addr = imem_req_addr;
      tick();
    end

    // Randomized run: memory with variable latency, random stalls, redirects and resets.
    m_pc = '0; m_oaddr = '0; m_bpc = '0; m_binstr = '0;
    m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, br, rr, rv, ir, e_rv;
      logic [31:0] tgt, data;
      r    = (i == 0) || ($urandom_range(0, 199) == 0);
      br   = !r && ($urandom_range(0, 7) == 0);
      tgt  = $urandom;
      rr   = ($urandom_range(0, 3) != 0);
      ir   = ($urandom_range(0, 2) != 0);
      rv   = !r && m_out && ($urandom_range(0, 1) == 1);
      data = $urandom;

      rst = r; br_en = br; br_target = tgt; imem_req_ready = rr;
      imem_rsp_valid = rv; imem_rsp_data = data; if_ready = ir;
      #1;
      e_rv = !r && !m_out && (!m_bv || ir);
      if (i > 0) begin
        check("rnd_req_valid", i, {31'b0, imem_req_valid}, {31'b0, e_rv});
        check("rnd_req_addr", i, imem_req_addr, m_pc);
        check("rnd_if_valid", i, {31'b0, if_valid}, {31'b0, m_bv});
        if (m_bv) begin
          check("rnd_if_pc", i, if_pc, m_bpc);
          check("rnd_if_instr", i, if_instr, m_binstr);
        end
      end

      if (r) begin
        m_pc = 32'h0; m_out = 1'b0; m_bv = 1'b0;
      end else begin
        if (m_bv && ir) m_bv = 1'b0;
        if (rv) begin
          if (!m_stale && !br) begin
            m_bv = 1'b1; m_bpc = m_oaddr; m_binstr = data;
          end
          m_out = 1'b0;
        end
        if (e_rv && rr) begin
          m_out = 1'b1; m_oaddr = m_pc; m_stale = 1'b0; m_pc = m_pc + 32'd4;
        end
        if (br) begin
          m_pc = {tgt[31:2], 2'b00};
          m_bv = 1'b0;
          if (m_out) m_stale = 1'b1;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
